// File: rtl/rf_pkg.sv
// Shared widths and types for the register file and its pending-write scoreboard.
package rf_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned SB_CNT_W  = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [SB_CNT_W-1:0]  sb_cnt_t;

  localparam sb_cnt_t SB_CNT_MAX = '1;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters (issued but not yet written back) with a
// sticky overflow flag; x0 is never tracked.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     issue_valid,
  input  reg_idx_t issue_num,
  input  logic     WE,
  input  reg_idx_t W_num,
  input  logic     flush,
  input  reg_idx_t rd_1_num,
  input  reg_idx_t rd_2_num,
  output sb_cnt_t  rd_1_cnt_c,
  output sb_cnt_t  rd_2_cnt_c,
  output logic     sb_overflow
);

  localparam logic [NUM_REGS-1:0] X0_MASK = NUM_REGS'(1);

  sb_cnt_t             cnt_q [NUM_REGS];
  sb_cnt_t             cnt_d [NUM_REGS];
  logic                ovf_d;
  logic [NUM_REGS-1:0] iss_hit;
  logic [NUM_REGS-1:0] wr_hit;

  // One-hot per-register event masks; x0 is masked so it never counts.
  assign iss_hit = issue_valid ? ((NUM_REGS'(1) << issue_num) & ~X0_MASK) : '0;
  assign wr_hit  = WE          ? ((NUM_REGS'(1) << W_num)     & ~X0_MASK) : '0;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = sb_overflow;
    if (flush) begin
      cnt_d = '{default: '0};
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (iss_hit[r] && !wr_hit[r]) begin
          if (cnt_q[r] == SB_CNT_MAX) ovf_d = 1'b1;
          else                        cnt_d[r] = cnt_q[r] + sb_cnt_t'(1);
        end else if (wr_hit[r] && !iss_hit[r] && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - sb_cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '{default: '0};
      sb_overflow <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sb_overflow <= ovf_d;
    end
  end

  assign rd_1_cnt_c = cnt_q[rd_1_num];
  assign rd_2_cnt_c = cnt_q[rd_2_num];

endmodule

// File: rtl/register_file_sb.sv
// 32x32 register file, two combinational read ports, one write port, plus a
// pending-write scoreboard. Define RF_BYPASS_EN for same-cycle write-to-read bypass.
module register_file_sb
  import rf_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  reg_idx_t w_R_1_num,
  input  reg_idx_t w_R_2_num,
  output xlen_t    w_R_1,
  output xlen_t    w_R_2,
  input  logic     WE,
  input  reg_idx_t W_num,
  input  xlen_t    W_data,
  input  logic     issue_valid,
  input  reg_idx_t issue_num,
  input  logic     flush,
  output logic     R_1_busy,
  output logic     R_2_busy,
  output logic     sb_overflow
);

  xlen_t   regs_q [NUM_REGS];
  sb_cnt_t rd_1_cnt;
  sb_cnt_t rd_2_cnt;

  // x0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '{default: '0};
    end else if (WE && (W_num != '0)) begin
      regs_q[W_num] <= W_data;
    end
  end

  rf_scoreboard u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_num   (issue_num),
    .WE          (WE),
    .W_num       (W_num),
    .flush       (flush),
    .rd_1_num    (w_R_1_num),
    .rd_2_num    (w_R_2_num),
    .rd_1_cnt_c  (rd_1_cnt),
    .rd_2_cnt_c  (rd_2_cnt),
    .sb_overflow (sb_overflow)
  );

`ifdef RF_BYPASS_EN
  logic byp_1;
  logic byp_2;

  // Bypass is held off during reset so reads stay zero while reset_n is low.
  always_comb begin
    byp_1    = reset_n && WE && (W_num == w_R_1_num) && (w_R_1_num != '0);
    byp_2    = reset_n && WE && (W_num == w_R_2_num) && (w_R_2_num != '0);
    w_R_1    = byp_1 ? W_data : regs_q[w_R_1_num];
    w_R_2    = byp_2 ? W_data : regs_q[w_R_2_num];
    R_1_busy = (w_R_1_num != '0) && (rd_1_cnt != '0)
               && !(byp_1 && (rd_1_cnt == sb_cnt_t'(1)));
    R_2_busy = (w_R_2_num != '0) && (rd_2_cnt != '0)
               && !(byp_2 && (rd_2_cnt == sb_cnt_t'(1)));
  end
`else
  always_comb begin
    w_R_1    = regs_q[w_R_1_num];
    w_R_2    = regs_q[w_R_2_num];
    R_1_busy = (w_R_1_num != '0) && (rd_1_cnt != '0);
    R_2_busy = (w_R_2_num != '0) && (rd_2_cnt != '0);
  end
`endif

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- w_R_1_num  in  5  read port 1 register index
- w_R_2_num  in  5  read port 2 register index
- w_R_1  out  32  read port 1 data
- w_R_2  out  32  read port 2 data
- WE  in  1  writeback write enable
- W_num  in  5  writeback destination index
- W_data  in  32  writeback data
- issue_valid  in  1  decode launched an instruction with RegWrite=1
- issue_num  in  5  destination index of that instruction
- flush  in  1  pipeline flush; discard all pending-write tracking
- R_1_busy  out  1  read port 1 register has a pending write
- R_2_busy  out  1  read port 2 register has a pending write
- sb_overflow  out  1  sticky pending-count overflow flag

Function
REQ-002 Storage SHALL be 32 entries x 32 bits; x0 SHALL read 0, ignore writes, and ignore issues.
REQ-003 Reads SHALL be combinational with zero latency: w_R_n = regs[w_R_n_num].
REQ-004 Writes SHALL occur at the rising edge of clk when WE=1 and W_num!=0.
REQ-005 Each register x1..x31 SHALL have a 2-bit pending counter, counting instructions issued but not yet written back (max 3).
REQ-006 At each clock edge, per register: issue only -> +1; WE only -> -1 (saturating at 0); issue and WE to the same register -> unchanged.
REQ-007 An issue to a register whose counter is 3, with no simultaneous WE to it, SHALL leave the counter at 3 and set sb_overflow, which stays 1 until reset.
REQ-008 flush=1 SHALL clear all counters at the next edge; issue and the counter decrement are ignored that cycle; the WE data write still occurs.
REQ-009 R_n_busy SHALL be 1 when w_R_n_num!=0 and its counter is nonzero, subject to REQ-011.

Reset
REQ-010 While reset_n=0, asynchronously: all 32 registers = 0, all counters = 0, sb_overflow = 0; consequently w_R_1 = w_R_2 = 0 and R_1_busy = R_2_busy = 0.

Configuration
REQ-011 With RF_BYPASS_EN defined:
- when WE=1 and W_num==w_R_n_num!=0, w_R_n SHALL equal W_data in the same cycle.
- R_n_busy SHALL be 0 when that register's counter is 1 and it is being written this cycle.
REQ-012 Without RF_BYPASS_EN, reads SHALL return the stored (pre-edge) value, and busy SHALL follow the counter only.

Structure
REQ-013 Package rf_pkg SHALL hold XLEN=32, NUM_REGS=32, REG_IDX_W=5, SB_CNT_W=2, and the reg_idx_t/xlen_t typedefs.
REQ-014 Counter logic SHALL be one sub-module, rf_scoreboard; storage and the bypass stay in register_file_sb.

Verification
REQ-015 Reset/zero: after reset, write x0=0xDEADBEEF -> w_R_1 (x0) = 0, busy = 0.
REQ-016 Write/read: WE x5=0x12345678 at edge N; read x5 at N+1 -> 0x12345678.
REQ-017 Bypass: WE x7=0xA5A5A5A5 while w_R_2_num=7, same cycle:
- with RF_BYPASS_EN -> w_R_2 = 0xA5A5A5A5;
- without -> the old value.
REQ-018 Scoreboard:
- issue x3 twice -> R_1_busy=1 (w_R_1_num=3);
- one WE x3 -> still busy;
- second WE -> busy=0.
REQ-019 Overflow and flush:
- four issues to x9 with no WE -> sb_overflow=1, counter 3;
- flush -> busy=0 and sb_overflow remains 1.
REQ-020 Simultaneous and reset:
- issue x4 and WE x4 in the same cycle with count=1 -> count stays 1;
- assert reset_n=0 mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
